ex_stage: RTL and testbench
===========================

EX_STAGE -- requirements
Module: ex_stage

Interface
REQ-001 SHALL have port clk, input, 1, rising-edge clock.
REQ-002 SHALL have port resetn, input, 1, synchronous active-low reset.
REQ-003 SHALL have ID/EX inputs, all input: validIn 1; immIn, rs1DataIn, rs2DataIn 32; rs1In, rs2In, rdIn 5; ALUSrcIn 1; ALUOpIn 4; memReadIn, memWriteIn, memToRegIn, regWriteIn 1.
REQ-004 SHALL have forwarding inputs, all input: memFwdRd 5, memFwdRegWrite 1, memFwdData 32 (EX/MEM instruction); wbFwdRd 5, wbFwdRegWrite 1, wbFwdData 32 (MEM/WB instruction).
REQ-005 SHALL have EX/MEM outputs, all registered output: validOut 1; aluResultOut, storeDataOut 32; rdOut 5; memReadOut, memWriteOut, memToRegOut, regWriteOut 1.
REQ-006 SHALL have port stall, output, 1, combinational; high means upstream stages (PC, IF/ID, ID/EX) hold.

Function
REQ-007 Forwarded operand fwdA SHALL be: memFwdData if memFwdRegWrite and memFwdRd!=0 and memFwdRd==rs1In; else wbFwdData under the same rule using wb* signals; else rs1DataIn. MEM has priority over WB.
REQ-008 fwdB SHALL use the REQ-007 rule with rs2In and rs2DataIn; storeData = fwdB.
REQ-009 Operand A = fwdA; operand B = immIn if ALUSrcIn else fwdB.
REQ-010 ALUOp encoding: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SRA, 8 SLT (signed), 9 SLTU, 10 MUL (low 32 bits of unsigned A*B), 11 MULHU (high 32 bits of unsigned A*B), 12-15 pass B.
REQ-011 Arithmetic SHALL be modulo 2^32; shifts use B[4:0] only; SLT/SLTU results are 0 or 1, zero-extended.
REQ-012 Ops 0-9 and 12-15 SHALL be single-cycle: the EX/MEM outputs load the result and the pass-through control/rd fields at the next rising edge; stall stays 0.
REQ-013 A multiplier FSM SHALL have states IDLE, BUSY, DONE.
REQ-014 IDLE: when validIn and ALUOpIn is 10 or 11, latch A, B, op, rdIn, and controls, clear the 64-bit product and the 5-bit counter, and go to BUSY.
REQ-015 BUSY: perform one shift-add step per cycle, 32 steps total, and go to DONE after the step at counter==31.
REQ-016 DONE: at the next edge, load the EX/MEM outputs from the latched fields, with aluResultOut = product[31:0] (MUL) or product[63:32] (MULHU); validOut=1; then go to IDLE.
REQ-017 stall SHALL equal validIn and (ALUOpIn is 10 or 11) and state!=DONE; this is high for 33 cycles per multiply and low in the DONE cycle.
REQ-018 While stall=1, each edge SHALL load a bubble: validOut, memReadOut, memWriteOut, regWriteOut, memToRegOut = 0; the data outputs are don't-care.
REQ-019 Multiply operands SHALL be taken from forwarding at IDLE acceptance only; changes on the forwarding buses during BUSY SHALL NOT affect the result.
REQ-020 If validIn=0, the next edge SHALL load a bubble and the FSM SHALL stay in IDLE.
REQ-021 Back-to-back multiplies: after DONE->IDLE, a multiply present in the following cycle SHALL start a new IDLE->BUSY sequence.
REQ-022 Control outputs SHALL be gated by validIn: an invalid input never produces regWriteOut, memReadOut, or memWriteOut = 1.

Reset
REQ-023 With resetn=0 at an edge, all registered outputs SHALL become 0, the FSM SHALL go to IDLE, and the counter and product SHALL clear.
REQ-024 During reset, stall SHALL be 0.
REQ-025 Reset mid-multiply SHALL abandon the operation; no result is ever emitted for it.

Verification
REQ-026 ADD, A=0x7FFFFFFF, B=1, no forwarding hazard -> next edge aluResultOut=0x80000000, validOut=1, stall=0.
REQ-027 Both hazards: rs1In=5, memFwdRd=5 (data 0x11), wbFwdRd=5 (data 0x22), both RegWrite=1, op ADD, B=imm 0 -> aluResultOut=0x11; with rs1In=0 and rd fields 0 -> aluResultOut equals rs1DataIn.
REQ-028 MUL, A=0xFFFFFFFF, B=0xFFFFFFFF -> stall high for 33 cycles, then one cycle low; the result edge gives aluResultOut=0x00000001; MULHU on the same operands gives 0xFFFFFFFE.
REQ-029 SRA, A=0x80000000, B=imm 0x21 -> aluResultOut=0xC0000000 (shift by 1); SLT, A=0xFFFFFFFF, B=1 -> 1; SLTU with the same operands -> 0.
REQ-030 resetn=0 pulsed at BUSY counter==10 -> all outputs 0 and stall=0 at the reset edge; the same multiply held on the inputs restarts and completes with the correct product.

Source files
------------

// File: rtl/ex_if.sv
// ID/EX -> EX -> EX/MEM bundle for the execute stage, including the operand-forwarding
// buses and the upstream stall request. The master side drives the ID/EX and forwarding signals.
interface ex_if;
  logic        validIn;
  logic [31:0] immIn, rs1DataIn, rs2DataIn;
  logic [4:0]  rs1In, rs2In, rdIn;
  logic        ALUSrcIn;
  logic [3:0]  ALUOpIn;
  logic        memReadIn, memWriteIn, memToRegIn, regWriteIn;
  logic [4:0]  memFwdRd, wbFwdRd;
  logic        memFwdRegWrite, wbFwdRegWrite;
  logic [31:0] memFwdData, wbFwdData;
  logic        validOut;
  logic [31:0] aluResultOut, storeDataOut;
  logic [4:0]  rdOut;
  logic        memReadOut, memWriteOut, memToRegOut, regWriteOut;
  logic        stall;

  modport master (
    output validIn, immIn, rs1DataIn, rs2DataIn, rs1In, rs2In, rdIn, ALUSrcIn, ALUOpIn,
           memReadIn, memWriteIn, memToRegIn, regWriteIn,
           memFwdRd, memFwdRegWrite, memFwdData, wbFwdRd, wbFwdRegWrite, wbFwdData,
    input  validOut, aluResultOut, storeDataOut, rdOut,
           memReadOut, memWriteOut, memToRegOut, regWriteOut, stall
  );

  modport slave (
    input  validIn, immIn, rs1DataIn, rs2DataIn, rs1In, rs2In, rdIn, ALUSrcIn, ALUOpIn,
           memReadIn, memWriteIn, memToRegIn, regWriteIn,
           memFwdRd, memFwdRegWrite, memFwdData, wbFwdRd, wbFwdRegWrite, wbFwdData,
    output validOut, aluResultOut, storeDataOut, rdOut,
           memReadOut, memWriteOut, memToRegOut, regWriteOut, stall
  );
endinterface

// File: rtl/ex_stage.sv
// Execute stage: operand forwarding, single-cycle ALU, and a 32-step shift-add multiplier
// that stalls the upstream stages until its result is written into the EX/MEM register.
module ex_stage (
  input logic clk,
  input logic resetn,
  ex_if.slave bus
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  state_e      state_q, state_d;
  logic [31:0] fwd_a, fwd_b, op_b;
  logic        is_mul;
  logic [63:0] pp;

  logic [31:0] mul_a_q, mul_a_d, mul_b_q, mul_b_d, mul_st_q, mul_st_d;
  logic        mul_hi_q, mul_hi_d;
  logic [4:0]  mul_rd_q, mul_rd_d;
  logic [3:0]  mul_ctl_q, mul_ctl_d;
  logic [63:0] prod_q, prod_d;
  logic [4:0]  cnt_q, cnt_d;

  logic        valid_q, valid_d, mrd_q, mrd_d, mwr_q, mwr_d, m2r_q, m2r_d, rw_q, rw_d;
  logic [31:0] res_q, res_d, st_q, st_d;
  logic [4:0]  rd_q, rd_d;

  function automatic logic [31:0] fwd_sel(
    input logic [4:0] rs, input logic [31:0] rf,
    input logic m_we, input logic [4:0] m_rd, input logic [31:0] m_data,
    input logic w_we, input logic [4:0] w_rd, input logic [31:0] w_data);
    if (m_we && m_rd != 5'd0 && m_rd == rs)      fwd_sel = m_data;
    else if (w_we && w_rd != 5'd0 && w_rd == rs) fwd_sel = w_data;
    else                                         fwd_sel = rf;
  endfunction

  function automatic logic [31:0] alu(input logic [3:0] op, input logic [31:0] a,
                                      input logic [31:0] b);
    logic signed [31:0] sa, sb;
    sa = a;
    sb = b;
    case (op)
      4'd0:    alu = a + b;
      4'd1:    alu = a - b;
      4'd2:    alu = a & b;
      4'd3:    alu = a | b;
      4'd4:    alu = a ^ b;
      4'd5:    alu = a << b[4:0];
      4'd6:    alu = a >> b[4:0];
      4'd7:    alu = sa >>> b[4:0];
      4'd8:    alu = {31'b0, sa < sb};
      4'd9:    alu = {31'b0, a < b};
      default: alu = b;
    endcase
  endfunction

  always_comb begin
    fwd_a  = fwd_sel(bus.rs1In, bus.rs1DataIn, bus.memFwdRegWrite, bus.memFwdRd, bus.memFwdData,
                     bus.wbFwdRegWrite, bus.wbFwdRd, bus.wbFwdData);
    fwd_b  = fwd_sel(bus.rs2In, bus.rs2DataIn, bus.memFwdRegWrite, bus.memFwdRd, bus.memFwdData,
                     bus.wbFwdRegWrite, bus.wbFwdRd, bus.wbFwdData);
    op_b   = bus.ALUSrcIn ? bus.immIn : fwd_b;
    is_mul = bus.validIn && (bus.ALUOpIn == 4'd10 || bus.ALUOpIn == 4'd11);
    pp     = mul_b_q[cnt_q] ? ({32'b0, mul_a_q} << cnt_q) : 64'd0;
  end

  // Reset forces stall low so upstream never holds on a stale multiply.
  assign bus.stall = resetn && is_mul && (state_q != DONE);

  always_comb begin
    state_d   = state_q;
    mul_a_d   = mul_a_q;
    mul_b_d   = mul_b_q;
    mul_st_d  = mul_st_q;
    mul_hi_d  = mul_hi_q;
    mul_rd_d  = mul_rd_q;
    mul_ctl_d = mul_ctl_q;
    prod_d    = prod_q;
    cnt_d     = cnt_q;
    case (state_q)
      IDLE: if (is_mul) begin
        mul_a_d   = fwd_a;
        mul_b_d   = op_b;
        mul_st_d  = fwd_b;
        mul_hi_d  = bus.ALUOpIn[0];
        mul_rd_d  = bus.rdIn;
        mul_ctl_d = {bus.memReadIn, bus.memWriteIn, bus.memToRegIn, bus.regWriteIn};
        prod_d    = 64'd0;
        cnt_d     = 5'd0;
        state_d   = BUSY;
      end
      BUSY: begin
        prod_d = prod_q + pp;
        cnt_d  = cnt_q + 5'd1;
        if (cnt_q == 5'd31) state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  // EX/MEM register: multiply result in DONE, ALU result in IDLE, bubble otherwise.
  always_comb begin
    valid_d = 1'b0;
    mrd_d   = 1'b0;
    mwr_d   = 1'b0;
    m2r_d   = 1'b0;
    rw_d    = 1'b0;
    res_d   = res_q;
    st_d    = st_q;
    rd_d    = rd_q;
    if (state_q == DONE) begin
      valid_d = 1'b1;
      res_d   = mul_hi_q ? prod_q[63:32] : prod_q[31:0];
      st_d    = mul_st_q;
      rd_d    = mul_rd_q;
      {mrd_d, mwr_d, m2r_d, rw_d} = mul_ctl_q;
    end else if (state_q == IDLE && !is_mul) begin
      valid_d = bus.validIn;
      mrd_d   = bus.memReadIn && bus.validIn;
      mwr_d   = bus.memWriteIn && bus.validIn;
      m2r_d   = bus.memToRegIn && bus.validIn;
      rw_d    = bus.regWriteIn && bus.validIn;
      res_d   = alu(bus.ALUOpIn, fwd_a, op_b);
      st_d    = fwd_b;
      rd_d    = bus.rdIn;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q   <= IDLE;
      mul_a_q   <= '0;
      mul_b_q   <= '0;
      mul_st_q  <= '0;
      mul_hi_q  <= 1'b0;
      mul_rd_q  <= '0;
      mul_ctl_q <= '0;
      prod_q    <= '0;
      cnt_q     <= '0;
      valid_q   <= 1'b0;
      mrd_q     <= 1'b0;
      mwr_q     <= 1'b0;
      m2r_q     <= 1'b0;
      rw_q      <= 1'b0;
      res_q     <= '0;
      st_q      <= '0;
      rd_q      <= '0;
    end else begin
      state_q   <= state_d;
      mul_a_q   <= mul_a_d;
      mul_b_q   <= mul_b_d;
      mul_st_q  <= mul_st_d;
      mul_hi_q  <= mul_hi_d;
      mul_rd_q  <= mul_rd_d;
      mul_ctl_q <= mul_ctl_d;
      prod_q    <= prod_d;
      cnt_q     <= cnt_d;
      valid_q   <= valid_d;
      mrd_q     <= mrd_d;
      mwr_q     <= mwr_d;
      m2r_q     <= m2r_d;
      rw_q      <= rw_d;
      res_q     <= res_d;
      st_q      <= st_d;
      rd_q      <= rd_d;
    end
  end

  assign bus.validOut     = valid_q;
  assign bus.aluResultOut = res_q;
  assign bus.storeDataOut = st_q;
  assign bus.rdOut        = rd_q;
  assign bus.memReadOut   = mrd_q;
  assign bus.memWriteOut  = mwr_q;
  assign bus.memToRegOut  = m2r_q;
  assign bus.regWriteOut  = rw_q;
endmodule

// File: tb/tb_ex_stage.sv
// Randomized bench for ex_stage: a transaction-level reference model predicts every EX/MEM
// output and the stall line each cycle, plus directed literal checks on key corner cases.
module tb_ex_stage;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  ex_if bus();
  ex_stage dut (.clk(clk), .resetn(resetn), .bus(bus));

  int total = 0;
  int bad = 0;
  logic started = 1'b0;

  // Reference model state: expected registered outputs and cycles spent on the current multiply.
  logic        e_valid = 0, e_mrd = 0, e_mwr = 0, e_m2r = 0, e_rw = 0;
  logic [31:0] e_res = 0, e_st = 0;
  logic [4:0]  e_rd = 0;
  int          mwait = 0;
  logic [31:0] ma = 0, mb = 0, mst = 0;
  logic [3:0]  mop = 0, mctl = 0;
  logic [4:0]  mrd = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] fwd(input logic [4:0] rs, input logic [31:0] rf);
    if (bus.memFwdRegWrite && bus.memFwdRd != 0 && bus.memFwdRd == rs) return bus.memFwdData;
    if (bus.wbFwdRegWrite && bus.wbFwdRd != 0 && bus.wbFwdRd == rs) return bus.wbFwdData;
    return rf;
  endfunction

  function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    logic [63:0] p;
    int sh;
    p = {32'b0, a} * {32'b0, b};
    sh = b % 32;
    case (op)
      0: return a + b;
      1: return a - b;
      2: return a & b;
      3: return a | b;
      4: return a ^ b;
      5: return a << sh;
      6: return a >> sh;
      7: return (a >> sh) | ((a[31] && sh != 0) ? ~(32'hFFFFFFFF >> sh) : 32'h0);
      8: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      9: return (a < b) ? 32'd1 : 32'd0;
      10: return p[31:0];
      11: return p[63:32];
      default: return b;
    endcase
  endfunction

  function automatic logic is_mul_in();
    return bus.validIn && (bus.ALUOpIn == 4'd10 || bus.ALUOpIn == 4'd11);
  endfunction

  always @(posedge clk) begin
    logic [31:0] a, b, fb;
    fb = fwd(bus.rs2In, bus.rs2DataIn);
    a  = fwd(bus.rs1In, bus.rs1DataIn);
    b  = bus.ALUSrcIn ? bus.immIn : fb;
    if (!resetn) begin
      {e_valid, e_mrd, e_mwr, e_m2r, e_rw} = '0;
      e_res = 0; e_st = 0; e_rd = 0; mwait = 0;
    end else if (is_mul_in() && mwait == 33) begin
      e_valid = 1; e_res = ref_alu(mop, ma, mb); e_st = mst; e_rd = mrd;
      {e_mrd, e_mwr, e_m2r, e_rw} = mctl;
      mwait = 0;
    end else if (is_mul_in()) begin
      if (mwait == 0) begin
        ma = a; mb = b; mst = fb; mop = bus.ALUOpIn; mrd = bus.rdIn;
        mctl = {bus.memReadIn, bus.memWriteIn, bus.memToRegIn, bus.regWriteIn};
      end
      {e_valid, e_mrd, e_mwr, e_m2r, e_rw} = '0;
      mwait++;
    end else begin
      e_valid = bus.validIn;
      e_mrd = bus.memReadIn && bus.validIn;
      e_mwr = bus.memWriteIn && bus.validIn;
      e_m2r = bus.memToRegIn && bus.validIn;
      e_rw  = bus.regWriteIn && bus.validIn;
      e_res = ref_alu(bus.ALUOpIn, a, b); e_st = fb; e_rd = bus.rdIn;
    end
  end

  always @(negedge clk) begin
    if (started) begin
      check("stall", {31'b0, bus.stall}, {31'b0, resetn && is_mul_in() && mwait != 33});
      check("validOut", {31'b0, bus.validOut}, {31'b0, e_valid});
      check("ctl", {28'b0, bus.memReadOut, bus.memWriteOut, bus.memToRegOut, bus.regWriteOut},
            {28'b0, e_mrd, e_mwr, e_m2r, e_rw});
      if (e_valid) begin
        check("aluResultOut", bus.aluResultOut, e_res);
        check("storeDataOut", bus.storeDataOut, e_st);
        check("rdOut", {27'b0, bus.rdOut}, {27'b0, e_rd});
      end
    end
  end

  task automatic set_fwd(input logic mwe, input logic [4:0] mrd_i, input logic [31:0] md,
                         input logic wwe, input logic [4:0] wrd, input logic [31:0] wd);
    bus.memFwdRegWrite = mwe; bus.memFwdRd = mrd_i; bus.memFwdData = md;
    bus.wbFwdRegWrite = wwe;  bus.wbFwdRd = wrd;    bus.wbFwdData = wd;
  endtask

  task automatic drive(input logic v, input logic [3:0] op, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic [4:0] rd, input logic [31:0] d1,
                       input logic [31:0] d2, input logic [31:0] imm, input logic src,
                       input logic [3:0] ctl);
    bus.validIn = v; bus.ALUOpIn = op; bus.rs1In = rs1; bus.rs2In = rs2; bus.rdIn = rd;
    bus.rs1DataIn = d1; bus.rs2DataIn = d2; bus.immIn = imm; bus.ALUSrcIn = src;
    {bus.memReadIn, bus.memWriteIn, bus.memToRegIn, bus.regWriteIn} = ctl;
  endtask

  // Hold the presented instruction until the stage accepts it; scramble forwarding while stalled.
  task automatic run(output int stalls);
    stalls = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!bus.stall) break;
      stalls++;
      @(posedge clk); #1;
      set_fwd($urandom_range(0, 1), 5'($urandom_range(0, 3)), $urandom,
              $urandom_range(0, 1), 5'($urandom_range(0, 3)), $urandom);
    end
    if (stalls >= 40) begin
      bad++; total++;
      $display("FAIL stall_timeout actual=%0d required=<40", stalls);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    int s;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 4'h0);
    set_fwd(0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    started = 1'b1;
    check("rst_valid", {31'b0, bus.validOut}, 32'd0);
    check("rst_res", bus.aluResultOut, 32'd0);
    check("rst_rw", {31'b0, bus.regWriteOut}, 32'd0);
    check("rst_stall", {31'b0, bus.stall}, 32'd0);
    resetn = 1'b1;

    drive(1, 0, 1, 2, 3, 32'h7FFFFFFF, 0, 32'd1, 1, 4'b0001);
    run(s);
    check("add_ovf", bus.aluResultOut, 32'h80000000);
    check("add_valid", {31'b0, bus.validOut}, 32'd1);
    check("add_stalls", 32'(s), 32'd0);

    set_fwd(1, 5, 32'h11, 1, 5, 32'h22);
    drive(1, 0, 5, 0, 7, 32'h99, 0, 0, 1, 4'b0001);
    run(s);
    check("fwd_mem_prio", bus.aluResultOut, 32'h11);
    set_fwd(0, 5, 32'h11, 1, 5, 32'h22);
    drive(1, 0, 5, 0, 7, 32'h99, 0, 0, 1, 4'b0001);
    run(s);
    check("fwd_wb", bus.aluResultOut, 32'h22);
    set_fwd(1, 0, 32'h11, 1, 0, 32'h22);
    drive(1, 0, 0, 0, 7, 32'h99, 0, 0, 1, 4'b0001);
    run(s);
    check("fwd_x0", bus.aluResultOut, 32'h99);

    drive(1, 10, 0, 0, 9, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0, 4'b0001);
    run(s);
    check("mul_stalls", 32'(s), 32'd33);
    check("mul_lo", bus.aluResultOut, 32'h00000001);
    drive(1, 11, 0, 0, 9, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0, 4'b0001);
    run(s);
    check("mulhu_hi", bus.aluResultOut, 32'hFFFFFFFE);

    drive(1, 7, 0, 0, 4, 32'h80000000, 0, 32'h21, 1, 4'b0001);
    run(s);
    check("sra", bus.aluResultOut, 32'hC0000000);
    drive(1, 8, 0, 0, 4, 32'hFFFFFFFF, 0, 32'd1, 1, 4'b0001);
    run(s);
    check("slt", bus.aluResultOut, 32'd1);
    drive(1, 9, 0, 0, 4, 32'hFFFFFFFF, 0, 32'd1, 1, 4'b0001);
    run(s);
    check("sltu", bus.aluResultOut, 32'd0);

    drive(0, 0, 0, 0, 4, 1, 2, 3, 0, 4'b1111);
    run(s);
    check("inv_ctl", {28'b0, bus.memReadOut, bus.memWriteOut, bus.memToRegOut, bus.regWriteOut},
          32'd0);

    // Reset while the multiplier counter sits at 10, then let the held multiply restart.
    drive(1, 10, 0, 0, 6, 32'd123457, 32'd98765, 0, 0, 4'b0001);
    repeat (11) @(posedge clk);
    #1;
    resetn = 1'b0;
    #1;
    check("rst_mid_stall", {31'b0, bus.stall}, 32'd0);
    @(posedge clk); #1;
    check("rst_mid_valid", {31'b0, bus.validOut}, 32'd0);
    check("rst_mid_res", bus.aluResultOut, 32'd0);
    check("rst_mid_rd", {27'b0, bus.rdOut}, 32'd0);
    resetn = 1'b1;
    run(s);
    check("rst_restart_stalls", 32'(s), 32'd33);
    check("rst_restart_prod", bus.aluResultOut, 32'd123457 * 32'd98765);

    for (int n = 0; n < 300; n++) begin
      logic [3:0] op;
      op = ($urandom_range(0, 9) == 0) ? 4'(10 + $urandom_range(0, 1)) : 4'($urandom_range(0, 15));
      set_fwd($urandom_range(0, 1), 5'($urandom_range(0, 3)), $urandom,
              $urandom_range(0, 1), 5'($urandom_range(0, 3)), $urandom);
      drive($urandom_range(0, 7) != 0, op, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            5'($urandom), $urandom, $urandom, $urandom, $urandom_range(0, 1), 4'($urandom));
      run(s);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
